// File: rtl/pmem_scheduler_if.sv
// ============================================================================
//  Module      : pmem_scheduler_if
//  Description : Bundle of the I-cache, D-cache and cacheline-adapter line
//                ports that meet at pmem_scheduler.
//                slave  - scheduler view (requests/adapter data in,
//                         responses/adapter request out)
//                master - environment view (caches + adapter)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pmem_scheduler_if;
  // Instruction cache side
  logic         instr_read;
  logic [31:0]  instr_addr;
  logic         instr_resp;
  logic [255:0] instr_rdata;
  // Data cache side
  logic         data_read;
  logic         data_write;
  logic [31:0]  data_addr;
  logic [255:0] data_wdata;
  logic         data_resp;
  logic [255:0] data_rdata;
  // Cacheline adapter side
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;

  modport slave (
    input  instr_read, instr_addr,
    input  data_read, data_write, data_addr, data_wdata,
    input  pmem_rdata, pmem_resp,
    output instr_resp, instr_rdata,
    output data_resp, data_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output instr_read, instr_addr,
    output data_read, data_write, data_addr, data_wdata,
    output pmem_rdata, pmem_resp,
    input  instr_resp, instr_rdata,
    input  data_resp, data_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/pmem_scheduler.sv
// ============================================================================
//  Module      : pmem_scheduler
//  Description : Shares the 256-bit cacheline-adapter port between the
//                I-cache and the D-cache. Arbitrates in IDLE (data wins by
//                default), latches the winner's line-aligned address, op and
//                write line, holds the adapter request until pmem_resp, then
//                pulses the winner's response for one cycle.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - pmem_scheduler_if.slave (cache and adapter ports)
//  Parameters  : STARVE_LIMIT - instruction-loss cycles before instruction is
//                forced to win (aging build only)
//  Options     : PMEM_SCHED_AGING_EN - when defined, a starvation counter lets
//                a long-waiting instruction request beat data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_scheduler #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  pmem_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t       r_state,        w_state_nxt;
  logic         r_pmem_read,    w_pmem_read_nxt;
  logic         r_pmem_write,   w_pmem_write_nxt;
  logic [31:0]  r_pmem_address, w_pmem_address_nxt;
  logic [255:0] r_pmem_wdata,   w_pmem_wdata_nxt;
  logic         r_instr_resp,   w_instr_resp_nxt;
  logic         r_data_resp,    w_data_resp_nxt;
  logic [255:0] r_instr_rdata,  w_instr_rdata_nxt;
  logic [255:0] r_data_rdata,   w_data_rdata_nxt;

  logic w_data_req;
  logic w_instr_pri;   // instruction beats data this IDLE cycle
  logic w_data_win;

  assign w_data_req = bus.data_read | bus.data_write;
  assign w_data_win = w_data_req & ~(bus.instr_read & w_instr_pri);

`ifdef PMEM_SCHED_AGING_EN
  localparam int unsigned          c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0]   c_sat   = {c_cnt_w{1'b1}};

  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               w_instr_grant;

  assign w_instr_grant = (r_state == ST_IDLE) & bus.instr_read & ~w_data_win;
  assign w_instr_pri   = (r_starve_cnt >= c_limit);

  // Counts every cycle the instruction side is waiting, including while a
  // data transaction is in flight; a grant to instruction wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_instr_grant) begin
      r_starve_cnt <= '0;
    end else if (bus.instr_read && (r_state != ST_SERVE_I) && (r_starve_cnt != c_sat)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  // Strict data-over-instruction priority; the limit folds away.
  assign w_instr_pri = 1'b0 && (STARVE_LIMIT != 0);
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_instr_resp   <= 1'b0;
      r_data_resp    <= 1'b0;
      r_instr_rdata  <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_write   <= w_pmem_write_nxt;
      r_pmem_address <= w_pmem_address_nxt;
      r_pmem_wdata   <= w_pmem_wdata_nxt;
      r_instr_resp   <= w_instr_resp_nxt;
      r_data_resp    <= w_data_resp_nxt;
      r_instr_rdata  <= w_instr_rdata_nxt;
      r_data_rdata   <= w_data_rdata_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_pmem_read_nxt    = r_pmem_read;
    w_pmem_write_nxt   = r_pmem_write;
    w_pmem_address_nxt = r_pmem_address;
    w_pmem_wdata_nxt   = r_pmem_wdata;
    w_instr_resp_nxt   = 1'b0;
    w_data_resp_nxt    = 1'b0;
    w_instr_rdata_nxt  = r_instr_rdata;
    w_data_rdata_nxt   = r_data_rdata;

    case (r_state)
      ST_IDLE: begin
        w_pmem_read_nxt  = 1'b0;
        w_pmem_write_nxt = 1'b0;
        if (w_data_win) begin
          w_pmem_address_nxt = {bus.data_addr[31:5], 5'b0};
          // Read and write together is treated as a write-back.
          if (bus.data_write) begin
            w_pmem_write_nxt = 1'b1;
            w_pmem_wdata_nxt = bus.data_wdata;
          end else begin
            w_pmem_read_nxt  = 1'b1;
          end
          w_state_nxt = ST_SERVE_D;
        end else if (bus.instr_read) begin
          w_pmem_address_nxt = {bus.instr_addr[31:5], 5'b0};
          w_pmem_read_nxt    = 1'b1;
          w_state_nxt        = ST_SERVE_I;
        end
      end

      ST_SERVE_I: begin
        if (bus.pmem_resp) begin
          w_instr_rdata_nxt = bus.pmem_rdata;
          w_pmem_read_nxt   = 1'b0;
          w_instr_resp_nxt  = 1'b1;
          w_state_nxt       = ST_RESP;
        end
      end

      ST_SERVE_D: begin
        if (bus.pmem_resp) begin
          if (r_pmem_read) begin
            w_data_rdata_nxt = bus.pmem_rdata;
          end
          w_pmem_read_nxt  = 1'b0;
          w_pmem_write_nxt = 1'b0;
          w_data_resp_nxt  = 1'b1;
          w_state_nxt      = ST_RESP;
        end
      end

      // Response pulse is already registered; the following IDLE cycle lets
      // the cache drop its request before arbitration runs again.
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_pmem_read_nxt  = 1'b0;
        w_pmem_write_nxt = 1'b0;
        w_state_nxt      = ST_IDLE;
      end
    endcase
  end

  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.instr_resp   = r_instr_resp;
  assign bus.instr_rdata  = r_instr_rdata;
  assign bus.data_resp    = r_data_resp;
  assign bus.data_rdata   = r_data_rdata;

endmodule

`default_nettype wire

// File: tb/tb_pmem_scheduler.sv
// ============================================================================
//  Module      : tb_pmem_scheduler
//  Description : Scoreboard bench for pmem_scheduler. Directed cache requests
//                push expected adapter transactions and cache responses into
//                queues; an adapter model and a response monitor pop and
//                compare them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pmem_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pmem_scheduler_if bus();

  pmem_scheduler #(.STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int           lat;
  } adp_t;

  typedef struct {
    logic         is_i;
    logic [255:0] rdata;
  } rsp_t;

  adp_t exp_adp[$];
  rsp_t exp_rsp[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_resp_cyc = -100;
  logic rst_q = 1'b1;
  int   spur_cnt = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [255:0] pat(input logic [31:0] s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s + 32'(i) * 32'h0101_0101;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic wr, input logic [31:0] addr, input logic [255:0] wd,
                            input logic [255:0] rd, input int lat,
                            input logic is_i, input logic [255:0] rsp_rdata);
    adp_t a;
    rsp_t r;
    a.wr = wr; a.addr = addr; a.wdata = wd; a.rdata = rd; a.lat = lat;
    r.is_i = is_i; r.rdata = rsp_rdata;
    exp_adp.push_back(a);
    exp_rsp.push_back(r);
  endtask

  // ---------------- adapter model ----------------
  task automatic serve_adapter();
    adp_t         e;
    logic         rd0, wr0, stable, aborted;
    logic [31:0]  a0;
    logic [255:0] w0;
    rd0 = bus.pmem_read; wr0 = bus.pmem_write;
    a0  = bus.pmem_address; w0 = bus.pmem_wdata;
    if (exp_adp.size() == 0) begin
      checks++; errors++;
      $display("FAIL adp_unexpected: got request addr %0h wr %0b expected none", a0, wr0);
      e.wr = wr0; e.addr = a0; e.wdata = w0; e.rdata = '0; e.lat = 4;
    end else begin
      e = exp_adp.pop_front();
      chk("adp_op_write", wr0, e.wr);
      chk("adp_op_read", rd0, !e.wr);
      chk("adp_addr", a0, e.addr);
      if (e.wr) chk("adp_wdata", w0, e.wdata);
    end
    chk("adp_gap", cyc >= last_resp_cyc + 3, 1'b1);
    stable = 1'b1; aborted = 1'b0;
    for (int k = 2; k <= e.lat; k++) begin
      @(negedge clk);
      if (rst_q) begin aborted = 1'b1; break; end
      if (bus.pmem_read !== rd0 || bus.pmem_write !== wr0 || bus.pmem_address !== a0 ||
          (wr0 && bus.pmem_wdata !== w0)) stable = 1'b0;
    end
    if (!aborted) begin
      chk("adp_stable", stable, 1'b1);
      bus.pmem_rdata = e.rdata;
      bus.pmem_resp  = 1'b1;
      last_resp_cyc  = cyc;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '1;
      if (!rst_q) chk("adp_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
    end
  endtask

  initial begin
    int spur_done;
    spur_done = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_q && (bus.pmem_read || bus.pmem_write)) begin
        serve_adapter();
      end else if (spur_cnt != spur_done) begin
        // Unsolicited completion while idle; must be ignored.
        spur_done = spur_cnt;
        bus.pmem_rdata = '1;
        bus.pmem_resp  = 1'b1;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.instr_resp || bus.data_resp) begin
        if (bus.instr_resp && bus.data_resp) begin
          checks++; errors++;
          $display("FAIL rsp_both: got instr_resp and data_resp together expected one");
        end else if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got instr_resp %0b data_resp %0b expected none",
                   bus.instr_resp, bus.data_resp);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_kind", bus.instr_resp, e.is_i);
          chk("rsp_latency", cyc - last_resp_cyc, 1);
          chk("rsp_rdata", e.is_i ? bus.instr_rdata : bus.data_rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic wait_resp(input logic is_i);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (is_i ? bus.instr_resp : bus.data_resp) return;
    end
    checks++; errors++;
    $display("FAIL timeout: got no %s response expected one within 300 cycles", is_i ? "instr" : "data");
  endtask

  task automatic i_req(input logic [31:0] addr);
    bus.instr_addr = addr;
    bus.instr_read = 1'b1;
    wait_resp(1'b1);
    bus.instr_read = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] addr, input logic rd, input logic wr, input logic [255:0] wd);
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    bus.data_read  = rd;
    bus.data_write = wr;
    wait_resp(1'b0);
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
  endtask

  // Back-to-back reads: a new address is presented in the response cycle.
  task automatic d_stream(input int n, input logic [31:0] base);
    bus.data_read = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.data_addr = base + 32'(k) * 32'h20;
      wait_resp(1'b0);
    end
    bus.data_read = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] dbeef;
    dbeef = {8{32'hDEADBEEF}};
    bus.instr_read = 1'b0; bus.instr_addr = '0;
    bus.data_read  = 1'b0; bus.data_write = 1'b0;
    bus.data_addr  = '0;   bus.data_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_pmem_read",    bus.pmem_read,    1'b0);
    chk("rst_pmem_write",   bus.pmem_write,   1'b0);
    chk("rst_pmem_address", bus.pmem_address, 32'h0);
    chk("rst_pmem_wdata",   bus.pmem_wdata,   '0);
    chk("rst_instr_resp",   bus.instr_resp,   1'b0);
    chk("rst_data_resp",    bus.data_resp,    1'b0);
    chk("rst_instr_rdata",  bus.instr_rdata,  '0);
    chk("rst_data_rdata",   bus.data_rdata,   '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single instruction read, unaligned address
    expect_txn(1'b0, 32'h0000_1220, '0, pat(32'h1111_0000), 4, 1'b1, pat(32'h1111_0000));
    i_req(32'h0000_1234);
    repeat (2) @(negedge clk);

    // Write-back; adapter returns junk that must not reach data_rdata
    expect_txn(1'b1, 32'h8000_0040, dbeef, pat(32'hBAD0_0000), 3, 1'b0, '0);
    d_req(32'h8000_0040, 1'b0, 1'b1, dbeef);
    repeat (2) @(negedge clk);

    // Simultaneous requests: data first, then instruction
    expect_txn(1'b0, 32'h0000_3000, '0, pat(32'h3000_0000), 2, 1'b0, pat(32'h3000_0000));
    expect_txn(1'b0, 32'h0000_2000, '0, pat(32'h2000_0000), 5, 1'b1, pat(32'h2000_0000));
    fork
      i_req(32'h0000_2000);
      d_req(32'h0000_3000, 1'b1, 1'b0, '0);
    join
    repeat (2) @(negedge clk);

    // Read and write together behave as a write
    expect_txn(1'b1, 32'h0000_4000, pat(32'h4444_0000), pat(32'hBAD1_0000), 3, 1'b0, pat(32'h3000_0000));
    d_req(32'h0000_4010, 1'b1, 1'b1, pat(32'h4444_0000));
    repeat (2) @(negedge clk);

    // Stray pmem_resp while idle
    spur_cnt = 1;
    repeat (3) @(negedge clk);
    chk("spur_pmem_read",   bus.pmem_read,   1'b0);
    chk("spur_instr_rdata", bus.instr_rdata, pat(32'h2000_0000));
    chk("spur_data_rdata",  bus.data_rdata,  pat(32'h3000_0000));

    // Instruction against a stream of data reads
`ifdef PMEM_SCHED_AGING_EN
    expect_txn(1'b0, 32'h0000_7000, '0, pat(32'h7000_0000), 4, 1'b0, pat(32'h7000_0000));
    expect_txn(1'b0, 32'h0000_7020, '0, pat(32'h7001_0000), 4, 1'b0, pat(32'h7001_0000));
    expect_txn(1'b0, 32'h0000_9000, '0, pat(32'h9000_0000), 4, 1'b1, pat(32'h9000_0000));
    expect_txn(1'b0, 32'h0000_7040, '0, pat(32'h7002_0000), 4, 1'b0, pat(32'h7002_0000));
    expect_txn(1'b0, 32'h0000_7060, '0, pat(32'h7003_0000), 4, 1'b0, pat(32'h7003_0000));
`else
    expect_txn(1'b0, 32'h0000_7000, '0, pat(32'h7000_0000), 4, 1'b0, pat(32'h7000_0000));
    expect_txn(1'b0, 32'h0000_7020, '0, pat(32'h7001_0000), 4, 1'b0, pat(32'h7001_0000));
    expect_txn(1'b0, 32'h0000_7040, '0, pat(32'h7002_0000), 4, 1'b0, pat(32'h7002_0000));
    expect_txn(1'b0, 32'h0000_7060, '0, pat(32'h7003_0000), 4, 1'b0, pat(32'h7003_0000));
    expect_txn(1'b0, 32'h0000_9000, '0, pat(32'h9000_0000), 4, 1'b1, pat(32'h9000_0000));
`endif
    fork
      i_req(32'h0000_9000);
      d_stream(4, 32'h0000_7000);
    join
    repeat (2) @(negedge clk);

    // Reset two cycles into a data read abandons it
    begin
      adp_t a;
      a.wr = 1'b0; a.addr = 32'h0000_5000; a.wdata = '0; a.rdata = pat(32'h5000_0000); a.lat = 20;
      exp_adp.push_back(a);
    end
    bus.data_addr = 32'h0000_5000;
    bus.data_read = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.pmem_read && n < 20) begin @(negedge clk); n++; end
      chk("abort_started", bus.pmem_read, 1'b1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data_read = 1'b0;
    chk("abort_pmem_read",    bus.pmem_read,    1'b0);
    chk("abort_pmem_write",   bus.pmem_write,   1'b0);
    chk("abort_pmem_address", bus.pmem_address, 32'h0);
    chk("abort_data_resp",    bus.data_resp,    1'b0);
    chk("abort_data_rdata",   bus.data_rdata,   '0);
    chk("abort_instr_rdata",  bus.instr_rdata,  '0);
    repeat (4) @(negedge clk);

    expect_txn(1'b0, 32'h0000_6000, '0, pat(32'h6000_0000), 4, 1'b1, pat(32'h6000_0000));
    i_req(32'h0000_6000);
    repeat (5) @(negedge clk);

    chk("adp_queue_empty", exp_adp.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pmem_scheduler.md
# pmem_scheduler

Shares the single 256-bit cacheline-adapter port between the instruction cache and the data cache. The block arbitrates line requests, latches the winning request's address and write data, and holds the adapter handshake until `pmem_resp` arrives. It then returns the line and a one-cycle response pulse to the winning cache. It sits between the two cache `pmem_*` ports and the cacheline adapter's line-side port in the top level.

## Interface
- `STARVE_LIMIT`, default 8: consecutive cycles of a pending instruction request lost to data before instruction is forced to win. Only used with the aging feature.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `instr_read` input 1: I-cache line-read request; held high until `instr_resp`.
- `instr_addr` input 32: I-cache line address.
- `instr_resp` output 1: one-cycle pulse; `instr_rdata` valid in the same cycle.
- `instr_rdata` output 256: line returned to I-cache.
- `data_read` input 1: D-cache line-read request; held until `data_resp`.
- `data_write` input 1: D-cache line write-back request; held until `data_resp`.
- `data_addr` input 32: D-cache line address.
- `data_wdata` input 256: write-back line.
- `data_resp` output 1: one-cycle pulse; `data_rdata` valid in the same cycle for reads.
- `data_rdata` output 256: line returned to D-cache.
- `pmem_rdata` input 256: line from the adapter.
- `pmem_resp` input 1: adapter completion; single-cycle pulse.
- `pmem_read` output 1: adapter read request.
- `pmem_write` output 1: adapter write request.
- `pmem_address` output 32: line-aligned address, `{addr[31:5], 5'b0}`.
- `pmem_wdata` output 256: latched write-back line.

## Operation
- FSM states:
  - IDLE: no transaction.
  - SERVE_I: serving an instruction read.
  - SERVE_D: serving a data read or write.
  - RESP: one-cycle response to the winning cache.
- Arbitration happens in IDLE only; default priority is data over instruction.
- On a grant, the block latches the winner's line-aligned address, the operation, and (for writes) `data_wdata`, then moves to SERVE_I or SERVE_D.
- In SERVE_x:
  - `pmem_read` or `pmem_write` is held high, with `pmem_address` and `pmem_wdata` stable, until `pmem_resp`.
  - On `pmem_resp`: register `pmem_rdata` into the winner's rdata register, drop `pmem_read`/`pmem_write` in the same edge, and go to RESP.
- RESP: pulse the winner's `*_resp` for exactly one cycle, then return to IDLE. The IDLE cycle that follows gives the cache time to deassert its request, so a stale request is never re-granted.
- If `data_read` and `data_write` are both high, the block treats it as a write.
- A requester that deasserts before its grant is dropped silently. Deassertion after the grant is ignored: the transaction completes and the response is still pulsed.
- `instr_rdata` and `data_rdata` hold their last value until overwritten by a new read.
- Any state other than the four above goes to IDLE (default branch).

## Timing
- Reset values:
  - state IDLE.
  - `pmem_read`, `pmem_write`, `instr_resp`, `data_resp` = 0.
  - `pmem_address` = 0; `pmem_wdata`, `instr_rdata`, `data_rdata` = 0.
  - starvation counter = 0.
- `rst` during SERVE_x or RESP abandons the transaction: outputs return to reset values on the next edge and no response is pulsed. The adapter shares `rst`.
- All outputs are registered.
  - Request first seen in IDLE at edge N: `pmem_read`/`pmem_write` high from cycle N+1.
  - `pmem_resp` at cycle M: `*_resp` high in cycle M+1, state back in IDLE at M+2.
  - Next `pmem_*` request no earlier than cycle M+3.
- If `pmem_resp` arrives in IDLE or RESP, it is ignored.

## Configuration
- `PMEM_SCHED_AGING_EN` defined:
  - A saturating counter of width `$clog2(STARVE_LIMIT+1)` increments each cycle `instr_read` is high while the state is not SERVE_I.
  - In IDLE with both requests pending and counter ≥ `STARVE_LIMIT`, instruction wins.
  - The counter clears on an instruction grant and on reset.
- Macro undefined: strict data-over-instruction priority; no counter is instantiated.

## Test plan
- Single I-read, addr 0x0000_1234, adapter returns a pattern after 4 cycles -> `pmem_address` = 0x0000_1220, `pmem_read` high for 4 cycles, `instr_resp` single pulse with `instr_rdata` equal to the pattern.
- D-write, addr 0x8000_0040, wdata = `{8{32'hDEADBEEF}}` -> `pmem_write` high, `pmem_wdata` stable until `pmem_resp`, then `data_resp` pulses once and `pmem_read` stays 0 throughout.
- I-read and D-read asserted in the same cycle -> data served first, then instruction granted after RESP+IDLE; exactly one `data_resp` then one `instr_resp`.
- Aging enabled, `STARVE_LIMIT`=8: instruction held high while back-to-back D-reads keep arriving -> instruction is granted on the first IDLE after the counter reaches 8. Aging disabled -> instruction waits until `data_read` drops.
- `rst` asserted 2 cycles into a D-read -> next cycle all outputs 0 and state IDLE, no `data_resp`; a new I-read afterwards completes normally.
- `data_read` and `data_write` both high -> adapter sees a write only.
